// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, state encoding and sizing helper for the BCD converter
//
// Contents:
//   bcd_state_e  : converter FSM states IDLE / SHIFT / DONE
//   DIGIT_W      : bits per BCD digit
//   ADJ_THRESH   : digit value at which double-dabble adds the offset
//   ADJ_OFFSET   : offset added so that a shift carries into the next digit
//   min_digits() : smallest DIGITS that holds every unsigned BIN_WIDTH value
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  localparam int DIGIT_W    = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_OFFSET = 3;

  // Decimal digits of 2^w - 1 equals ceil(w * log10(2)); 2^w is never a power
  // of ten, so the ceiling never lands exactly on an integer.
  function automatic int min_digits(input int bin_width);
    return (bin_width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one double-dabble digit cell: add 3 when the digit is 5 or more
//
// Ports:
//   digit_i : BCD digit before the shift
//   digit_o : digit corrected so that the following left shift stays in BCD
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= DIGIT_W'(ADJ_THRESH)) ? digit_i + DIGIT_W'(ADJ_OFFSET)
                                                     : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to BCD converter, one bit per clock
//
// Optional feature macro: BIN_TO_BCD_SEQ_SIGNED_EN (two's complement input, sign on out_neg).
//
// Parameters:
//   BIN_WIDTH : input word width (>= 2)
//   DIGITS    : BCD digits produced (>= 1)
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : input handshake, in_bin captured on in_valid && in_ready
//   in_bin                 : binary word to convert
//   out_valid/out_ready    : result handshake, result held while out_valid && !out_ready
//   out_bcd                : DIGITS packed digits, units digit in [3:0]
//   out_ndigits            : count of significant digits (1..DIGITS), DIGITS on overflow
//   out_neg                : result is negative (0 unless signed build)
//   out_ovf                : value needed more than DIGITS digits
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BIN_WIDTH-1:0]           in_bin,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [4*DIGITS-1:0]            out_bcd,
  output logic [$clog2(DIGITS+1)-1:0]    out_ndigits,
  output logic                           out_neg,
  output logic                           out_ovf
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH);
  localparam int ND_W  = $clog2(DIGITS + 1);

  bcd_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // BCD field in the upper BCD_W bits, binary word still to be shifted in below it.
  logic [SR_W-1:0]      sr_q, sr_d;
  logic                 ovf_q, ovf_d;

  logic [BCD_W-1:0]     bcd_adj;
  logic [SR_W-1:0]      sr_adj;
  logic [BIN_WIDTH-1:0] mag;
  logic [ND_W-1:0]      ndigits;

  // ------------------------------------------------------------------
  // Per-digit adjust cells on the BCD field of the shift register
  // ------------------------------------------------------------------
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (sr_q[BIN_WIDTH + DIGIT_W*g +: DIGIT_W]),
      .digit_o (bcd_adj[DIGIT_W*g +: DIGIT_W])
    );
  end

  assign sr_adj = {bcd_adj, sr_q[BIN_WIDTH-1:0]};

  // ------------------------------------------------------------------
  // Magnitude of the captured word and sign flag
  // ------------------------------------------------------------------
`ifdef BIN_TO_BCD_SEQ_SIGNED_EN
  logic neg_q;

  // The most negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so no extra width is needed.
  assign mag = in_bin[BIN_WIDTH-1] ? (~in_bin + BIN_WIDTH'(1)) : in_bin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      neg_q <= in_bin[BIN_WIDTH-1];
    end
  end

  assign out_neg = neg_q;
`else
  assign mag     = in_bin;
  assign out_neg = 1'b0;
`endif

  // ------------------------------------------------------------------
  // FSM and datapath next state
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sr_d    = {{BCD_W{1'b0}}, mag};
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_WIDTH - 1);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // A bit leaving the top digit is a carry worth 10^DIGITS; dropping it
        // leaves the low DIGITS digits of the true value intact.
        sr_d  = {sr_adj[SR_W-2:0], 1'b0};
        ovf_d = ovf_q | sr_adj[SR_W-1];
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      ovf_q   <= ovf_d;
    end
  end

  // ------------------------------------------------------------------
  // Result outputs
  // ------------------------------------------------------------------
  assign out_bcd = sr_q[SR_W-1 -: BCD_W];
  assign out_ovf = ovf_q;

  // Highest nonzero digit wins; an all-zero result still reports one digit.
  always_comb begin
    ndigits = ND_W'(1);
    for (int d = 0; d < DIGITS; d++) begin
      if (out_bcd[DIGIT_W*d +: DIGIT_W] != '0) begin
        ndigits = ND_W'(d + 1);
      end
    end
    if (ovf_q) begin
      ndigits = ND_W'(DIGITS);
    end
  end

  assign out_ndigits = ndigits;

endmodule
